// File: rtl/flow_route_ctrl.sv
// Valve sequencing controller for N_SRC chains of flow switches feeding a shared merge junction.
// Optional flush phase is built only when FLOW_ROUTE_FLUSH_EN is defined; otherwise dwell exits straight to DONE.
module flow_route_ctrl #(
   parameter int N_SRC   = 2,
   parameter int N_STAGE = 6,
   parameter int SETTLE  = 4,
   parameter int FLUSH   = 8,
   localparam int SW  = (N_SRC > 1) ? $clog2(N_SRC) : 1,
   localparam int KW  = (N_STAGE > 1) ? $clog2(N_STAGE) : 1,
   localparam int TW  = N_SRC * N_STAGE,
   localparam int SVW = 2 * N_SRC * N_STAGE
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [SW-1:0]   req_src,
   input  logic [KW-1:0]   req_stage,
   input  logic            req_side,
   input  logic [7:0]      req_dwell,
   input  logic            abort,
   output logic [TW-1:0]   thru_valve,
   output logic [SVW-1:0]  side_valve,
   output logic [N_SRC-1:0] merge_valve,
   output logic            busy,
   output logic            done,
   output logic            err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_DWELL,
      ST_FLUSH,
      ST_DONE
   } state_t;

   localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);
   localparam logic [7:0] FLUSH_CNT  = 8'(FLUSH);

   state_t      state;
   state_t      state_next;
   logic [7:0]  cnt;
   logic [7:0]  cnt_next;
   logic        err_next;
   logic        load;
   logic        exit_open;
   logic        illegal;

   logic [SW-1:0] lat_src;
   logic [KW-1:0] lat_stage;
   logic          lat_side;
   logic [7:0]    lat_dwell;

   logic [31:0]        src_i;
   logic [31:0]        stage_i;
   logic [N_STAGE-1:0] stage_mask;
   logic [N_SRC-1:0]   one_src;

   assign illegal = (32'(req_src) >= N_SRC) || (32'(req_stage) >= N_STAGE) ||
                    (req_dwell == 8'd0);

   assign src_i   = 32'(lat_src);
   assign stage_i = 32'(lat_stage);

   function automatic logic [7:0] dec_sat(input logic [7:0] c);
      return (c > 8'd1) ? c - 8'd1 : 8'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= 8'd0;
         err       <= 1'b0;
         lat_src   <= '0;
         lat_stage <= '0;
         lat_side  <= 1'b0;
         lat_dwell <= 8'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         err   <= err_next;
         if (load) begin
            lat_src   <= req_src;
            lat_stage <= req_stage;
            lat_side  <= req_side;
            lat_dwell <= req_dwell;
         end
      end
   end

   // Abort and dwell expiry share one exit path so the flush counter is always reloaded.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      err_next   = 1'b0;
      load       = 1'b0;
      exit_open  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (illegal) begin
                  err_next = 1'b1;
               end else begin
                  state_next = ST_PRIME;
                  cnt_next   = SETTLE_CNT;
                  load       = 1'b1;
               end
            end
         end
         ST_PRIME: begin
            if (abort) begin
               exit_open = 1'b1;
            end else if (cnt <= 8'd1) begin
               state_next = ST_DWELL;
               cnt_next   = lat_dwell;
            end else begin
               cnt_next = dec_sat(cnt);
            end
         end
         ST_DWELL: begin
            if (abort || cnt <= 8'd1) begin
               exit_open = 1'b1;
            end else begin
               cnt_next = dec_sat(cnt);
            end
         end
`ifdef FLOW_ROUTE_FLUSH_EN
         ST_FLUSH: begin
            if (cnt <= 8'd1) begin
               state_next = ST_DONE;
            end else begin
               cnt_next = dec_sat(cnt);
            end
         end
`endif
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (exit_open) begin
`ifdef FLOW_ROUTE_FLUSH_EN
         state_next = ST_FLUSH;
`else
         state_next = ST_DONE;
`endif
         cnt_next = FLUSH_CNT;
      end
   end

   always_comb begin
      stage_mask = '0;
      for (int k = 0; k < N_STAGE; k++) begin
         stage_mask[k] = (k < stage_i);
      end
      one_src    = '0;
      one_src[0] = 1'b1;
   end

   // Valves are a pure decode of state and latched fields, so reset closes them immediately.
   always_comb begin
      thru_valve  = '0;
      side_valve  = '0;
      merge_valve = '0;
      case (state)
         ST_PRIME, ST_DWELL: begin
            thru_valve = TW'(stage_mask) << (src_i * N_STAGE);
            side_valve = SVW'(1) << (2 * (src_i * N_STAGE + stage_i) + 32'(lat_side));
         end
`ifdef FLOW_ROUTE_FLUSH_EN
         ST_FLUSH: begin
            thru_valve  = TW'({N_STAGE{1'b1}}) << (src_i * N_STAGE);
            merge_valve = one_src << src_i;
         end
`endif
         default: begin
            thru_valve  = '0;
            side_valve  = '0;
            merge_valve = '0;
         end
      endcase
   end

   assign req_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_flow_route_ctrl.sv
// Bench for flow_route_ctrl: a timeline model predicts every output each cycle, plus literal spot checks.
// Honours FLOW_ROUTE_FLUSH_EN the same way the design does.
module tb_flow_route_ctrl;

   localparam int N_SRC   = 2;
   localparam int N_STAGE = 6;
   localparam int SETTLE  = 4;
   localparam int FLUSH   = 8;
`ifdef FLOW_ROUTE_FLUSH_EN
   localparam int F_EFF = FLUSH;
`else
   localparam int F_EFF = 0;
`endif

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [0:0]  req_src;
   logic [2:0]  req_stage;
   logic        req_side;
   logic [7:0]  req_dwell;
   logic        abort;
   logic [11:0] thru_valve;
   logic [23:0] side_valve;
   logic [1:0]  merge_valve;
   logic        busy;
   logic        done;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   flow_route_ctrl #(
      .N_SRC(N_SRC), .N_STAGE(N_STAGE), .SETTLE(SETTLE), .FLUSH(FLUSH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src(req_src), .req_stage(req_stage), .req_side(req_side), .req_dwell(req_dwell),
      .abort(abort),
      .thru_valve(thru_valve), .side_valve(side_valve), .merge_valve(merge_valve),
      .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one operation is a timeline measured from its accept edge.
   bit m_active   = 0;
   int cyc        = 0;
   int m_t0       = 0;
   int m_err_cyc  = -1;
   int m_src, m_stage, m_side, m_open_end;

   always @(posedge clk or negedge rst_n) begin
      bit idle_before;
      int ci_prev;
      if (!rst_n) begin
         m_active  = 0;
         m_err_cyc = -1;
         cyc       = 0;
      end else begin
         idle_before = !m_active;
         if (m_active) begin
            ci_prev = cyc - m_t0 + 1;
            if (abort && ci_prev >= 1 && ci_prev <= m_open_end) m_open_end = ci_prev;
            if (ci_prev == m_open_end + F_EFF + 1) m_active = 0;
         end
         cyc++;
         if (idle_before && req_valid) begin
            if (int'(req_src) >= N_SRC || int'(req_stage) >= N_STAGE || req_dwell == 8'd0) begin
               m_err_cyc = cyc;
            end else begin
               m_active   = 1;
               m_t0       = cyc;
               m_src      = int'(req_src);
               m_stage    = int'(req_stage);
               m_side     = int'(req_side);
               m_open_end = SETTLE + int'(req_dwell);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [63:0] e_thru, e_side, e_merge;
      logic        e_done;
      int ci;
      e_thru  = 64'd0;
      e_side  = 64'd0;
      e_merge = 64'd0;
      e_done  = 1'b0;
      if (m_active) begin
         ci = cyc - m_t0 + 1;
         if (ci <= m_open_end) begin
            e_thru = ((64'd1 << m_stage) - 64'd1) << (m_src * N_STAGE);
            e_side = 64'd1 << (2 * (m_src * N_STAGE + m_stage) + m_side);
         end else if (ci <= m_open_end + F_EFF) begin
            e_thru  = ((64'd1 << N_STAGE) - 64'd1) << (m_src * N_STAGE);
            e_merge = 64'd1 << m_src;
         end else begin
            e_done = 1'b1;
         end
      end
      check_output("thru_valve", 64'(thru_valve), e_thru);
      check_output("side_valve", 64'(side_valve), e_side);
      check_output("merge_valve", 64'(merge_valve), e_merge);
      check_output("done", 64'(done), 64'(e_done));
      check_output("busy", 64'(busy), 64'(m_active));
      check_output("req_ready", 64'(req_ready), 64'(!m_active));
      check_output("err", 64'(err), 64'(cyc == m_err_cyc));
   end

   // Presents one request for a single edge; returns in cycle 1 after the accept edge.
   task automatic apply_stimulus(input int src, input int stage, input int side, input int dwell);
      @(negedge clk); #1;
      req_valid = 1'b1;
      req_src   = 1'(src);
      req_stage = 3'(stage);
      req_side  = 1'(side);
      req_dwell = 8'(dwell);
      @(negedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic advance(input int n);
      repeat (n) begin
         @(negedge clk); #1;
      end
   endtask

   task automatic wait_done(input int start, output int lat);
      lat = start;
      while (done !== 1'b1 && lat < 500) begin
         @(negedge clk); #1;
         lat++;
      end
      if (done !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL done_timeout: done never rose, expected within 500 cycles");
      end
   endtask

   initial begin
      int lat;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_src   = '0;
      req_stage = '0;
      req_side  = 1'b0;
      req_dwell = 8'd0;
      abort     = 1'b0;
      #2;
      check_output("rst_ready", 64'(req_ready), 64'd1);
      check_output("rst_busy", 64'(busy), 64'd0);
      check_output("rst_thru", 64'(thru_valve), 64'd0);
      advance(3);
      rst_n = 1'b1;

      $display("[TB] basic route src0 stage3 side1 dwell5");
      apply_stimulus(0, 3, 1, 5);
      check_output("a_thru_prime", 64'(thru_valve), 64'h007);
      check_output("a_side_prime", 64'(side_valve), 64'h80);
      advance(9);
`ifdef FLOW_ROUTE_FLUSH_EN
      check_output("a_thru_flush", 64'(thru_valve), 64'h03F);
      check_output("a_merge_flush", 64'(merge_valve), 64'h1);
      check_output("a_side_flush", 64'(side_valve), 64'h0);
`endif
      wait_done(10, lat);
      check_output("a_latency", 64'(lat), 64'(SETTLE + 5 + F_EFF + 1));

      $display("[TB] request held through DONE, src1 stage0 side0 dwell1");
      req_valid = 1'b1;
      req_src   = 1'd1;
      req_stage = 3'd0;
      req_side  = 1'b0;
      req_dwell = 8'd1;
      advance(1);
      check_output("b_not_taken_in_done", 64'(busy), 64'd0);
      advance(1);
      req_valid = 1'b0;
      check_output("b_busy", 64'(busy), 64'd1);
      check_output("b_thru_prime", 64'(thru_valve), 64'h0);
      check_output("b_side_prime", 64'(side_valve), 64'h1000);
      wait_done(1, lat);
      check_output("b_latency", 64'(lat), 64'(SETTLE + 1 + F_EFF + 1));

      $display("[TB] src1 stage0 side1 dwell1");
      apply_stimulus(1, 0, 1, 1);
      check_output("c_side_prime", 64'(side_valve), 64'h2000);
      advance(5);
`ifdef FLOW_ROUTE_FLUSH_EN
      check_output("c_thru_flush", 64'(thru_valve), 64'hFC0);
      check_output("c_merge_flush", 64'(merge_valve), 64'h2);
`endif
      wait_done(6, lat);
      check_output("c_latency", 64'(lat), 64'(SETTLE + 1 + F_EFF + 1));
      advance(1);

      $display("[TB] illegal requests");
      apply_stimulus(0, 6, 0, 3);
      check_output("d_err_stage", 64'(err), 64'd1);
      check_output("d_ready_stage", 64'(req_ready), 64'd1);
      advance(1);
      check_output("d_err_clear", 64'(err), 64'd0);
      apply_stimulus(1, 2, 0, 0);
      check_output("d_err_dwell", 64'(err), 64'd1);
      check_output("d_side_dwell", 64'(side_valve), 64'h0);

      $display("[TB] abort in IDLE, then abort in second DWELL cycle and into FLUSH");
      abort = 1'b1;
      apply_stimulus(0, 2, 0, 5);
      abort = 1'b0;
      check_output("e_accepted", 64'(busy), 64'd1);
      advance(5);
      abort = 1'b1;
      advance(1);
`ifdef FLOW_ROUTE_FLUSH_EN
      check_output("e_thru_flush", 64'(thru_valve), 64'h03F);
      check_output("e_merge_flush", 64'(merge_valve), 64'h1);
      advance(1);
      abort = 1'b0;
      wait_done(8, lat);
      check_output("e_latency", 64'(lat), 64'd15);
`else
      check_output("e_done_after_abort", 64'(done), 64'd1);
      advance(1);
      abort = 1'b0;
`endif
      advance(1);

      $display("[TB] reset during DWELL, then normal request");
      apply_stimulus(1, 4, 1, 3);
      advance(5);
      check_output("f_thru_dwell", 64'(thru_valve), 64'h3C0);
      check_output("f_side_dwell", 64'(side_valve), 64'h200000);
      #1;
      rst_n = 1'b0;
      #1;
      check_output("f_rst_thru", 64'(thru_valve), 64'h0);
      check_output("f_rst_side", 64'(side_valve), 64'h0);
      check_output("f_rst_ready", 64'(req_ready), 64'd1);
      check_output("f_rst_busy", 64'(busy), 64'd0);
      advance(1);
      rst_n = 1'b1;
      apply_stimulus(0, 5, 0, 2);
      check_output("f_thru_after", 64'(thru_valve), 64'h01F);
      check_output("f_side_after", 64'(side_valve), 64'h400);
      wait_done(1, lat);
      check_output("f_latency", 64'(lat), 64'(SETTLE + 2 + F_EFF + 1));

      advance(3);
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/flow_route_ctrl.md
FLOW_ROUTE_CTRL -- requirements
Module: flow_route_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 2: number of source chains feeding the shared merge junction.
REQ-002 SHALL have parameter N_STAGE, default 6: number of four-port flow switches per source chain.
REQ-003 SHALL have parameter SETTLE, default 4: valve settle time in cycles, legal range 1..255.
REQ-004 SHALL have parameter FLUSH, default 8: flush time in cycles, legal range 1..255.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous, active-low.
REQ-007 req_valid  in  1  routing request present.
REQ-008 req_ready  out  1  controller accepts a request this cycle.
REQ-009 req_src  in  clog2(N_SRC)  source chain index.
REQ-010 req_stage  in  clog2(N_STAGE)  target flow switch index within the chain.
REQ-011 req_side  in  1  side outlet select: 0 = port3 chamber, 1 = port0 chamber.
REQ-012 req_dwell  in  8  dwell cycles with the chamber open; 0 is illegal.
REQ-013 abort  in  1  cancel the operation in progress.
REQ-014 thru_valve  out  N_SRC*N_STAGE  chain through-valve opens, bit s*N_STAGE+k.
REQ-015 side_valve  out  2*N_SRC*N_STAGE  side valve opens, bit 2*(s*N_STAGE+k)+side.
REQ-016 merge_valve  out  N_SRC  merge-junction inlet opens.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse when an operation completes.
REQ-019 err  out  1  one-cycle pulse when an illegal request is rejected.

Function
REQ-020 FSM states SHALL be IDLE, PRIME, DWELL, FLUSH and DONE; req_ready SHALL equal (state==IDLE).
REQ-021 A request SHALL be accepted on req_valid&&req_ready, which latches src, stage, side and dwell.
REQ-022 A request with req_src>=N_SRC, req_stage>=N_STAGE or req_dwell==0 SHALL pulse err on the next cycle, stay in IDLE, and leave all valves closed.
REQ-023 IDLE->PRIME on a legal accept; in PRIME, thru_valve bits s*N_STAGE+0..stage-1 and side valve (s,stage,side) SHALL be open for exactly SETTLE cycles.
REQ-024 PRIME->DWELL; DWELL SHALL hold the PRIME valve set for exactly the latched dwell cycles, counting down to 1.
REQ-025 DWELL->FLUSH; FLUSH SHALL close all side valves and open all N_STAGE through valves of source s plus merge_valve[s] for exactly FLUSH cycles.
REQ-026 FLUSH->DONE; DONE SHALL last one cycle with done=1 and all valves closed, then return to IDLE.
REQ-027 Request-to-done latency SHALL be SETTLE+dwell+FLUSH+2 cycles, counting the accept edge as cycle 0 (done high in cycle SETTLE+dwell+FLUSH+1).
REQ-028 At most one merge_valve bit SHALL be high at any time, and no side valve SHALL be open while any merge_valve bit is high.
REQ-029 When abort is high in PRIME or DWELL, the FSM SHALL go to FLUSH on the next edge with the flush counter reloaded.
REQ-030 When abort is high in FLUSH, the flush SHALL complete unchanged; abort SHALL be ignored in IDLE and DONE.
REQ-031 When req_valid and abort are both high in IDLE, the request SHALL be accepted.
REQ-032 A request presented in the DONE cycle SHALL NOT be accepted; it SHALL be accepted in the following IDLE cycle.
REQ-033 Counters SHALL be 8-bit down-counters that never wrap below 1.

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, clear counters and latched fields, and drive all valve outputs, busy, done and err to 0; req_ready SHALL be 1 while rst_n is low.
REQ-035 Reset asserted mid-operation SHALL close all valves within the same cycle, with no flush performed.

Configuration
REQ-036 Macro FLOW_ROUTE_FLUSH_EN: when defined, the FLUSH state SHALL exist as specified above.
REQ-037 When FLOW_ROUTE_FLUSH_EN is undefined, DWELL and abort SHALL transition directly to DONE, merge_valve SHALL be constant 0, and latency SHALL be SETTLE+dwell+2.

Verification
REQ-038 Defaults, src=0, stage=3, side=1, dwell=5 -> thru bits 0..2 and side bit 7 open for 9 cycles, then thru 0..5 and merge[0] open for 8 cycles, done pulses in cycle 18.
REQ-039 src=1, stage=0, dwell=1 -> no thru valve open during PRIME/DWELL, side bit 12 or 13 per side, merge[1] only in FLUSH.
REQ-040 stage=6, or dwell=0 -> err pulse, req_ready stays 1, all valves remain 0.
REQ-041 abort in the 2nd DWELL cycle -> FLUSH begins on the next edge and lasts 8 cycles, then done.
REQ-042 rst_n dropped in DWELL -> outputs go to 0 asynchronously; after release, req_ready=1 and a new request is served normally.
REQ-043 Build without FLOW_ROUTE_FLUSH_EN, dwell=5 -> done in cycle 10, merge_valve never high.
